// File: rtl/i2s_wav_pkg.sv
// i2s_wav_pkg: shared constants for the I2S WAV transmitter.
// Default timing, slot bit offsets and frame-length helper.
package i2s_wav_pkg;

    localparam int BCLK_HALF_DEF = 9;
    localparam int SLOT_BITS_DEF = 32;
    localparam int SAMPLE_W_DEF  = 16;

    // Philips alignment: MSB sits one BCLK after the LRCK edge
    localparam int MSB_OFS    = 1;
    // Sample request lead, in BCLKs before the slot ends
    localparam int FETCH_LEAD = 4;

    function automatic int frame_bits(input int slot_bits);
        return 2 * slot_bits;
    endfunction

endpackage

// File: rtl/i2s_clk_gen.sv
// i2s_clk_gen: BCLK divider and frame bit counter for the I2S master.
// Ports: clk_50M, rst_n in; i2s_bclk, i2s_lrck, fall_tick, bit_cnt out.
module i2s_clk_gen
    import i2s_wav_pkg::*;
#(
    parameter int BCLK_HALF = BCLK_HALF_DEF,
    parameter int SLOT_BITS = SLOT_BITS_DEF,
    parameter int BW        = $clog2(frame_bits(SLOT_BITS))
) (
    input  logic          clk_50M,
    input  logic          rst_n,
    output logic          i2s_bclk,
    output logic          i2s_lrck,
    output logic          fall_tick,
    output logic [BW-1:0] bit_cnt
);

    localparam int FRAME = frame_bits(SLOT_BITS);
    localparam int DW    = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;

    logic [DW-1:0] div_cnt;
    logic          wrap;

    assign wrap      = (div_cnt == DW'(BCLK_HALF - 1));
    assign fall_tick = wrap & i2s_bclk;
    assign i2s_lrck  = bit_cnt[BW-1];

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt  <= '0;
            i2s_bclk <= 1'b0;
        end else if (wrap) begin
            div_cnt  <= '0;
            i2s_bclk <= ~i2s_bclk;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= '0;
        end else if (fall_tick) begin
            if (bit_cnt == BW'(FRAME - 1))
                bit_cnt <= '0;
            else
                bit_cnt <= bit_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/i2s_wav_tx.sv
// i2s_wav_tx: pulls 16-bit PCM from the SD buffer, drives Philips I2S.
// Ports: clk_50M, rst_n, play_en, wav_data in; wav_rden, i2s_bclk,
// i2s_lrck, i2s_dout out. Macro I2S_WAV_TX_MONO_DUP_EN: one read per
// frame, same sample in both slots.
module i2s_wav_tx
    import i2s_wav_pkg::*;
#(
    parameter int BCLK_HALF = BCLK_HALF_DEF,
    parameter int SLOT_BITS = SLOT_BITS_DEF,
    parameter int SAMPLE_W  = SAMPLE_W_DEF
) (
    input  logic                clk_50M,
    input  logic                rst_n,
    input  logic                play_en,
    output logic                wav_rden,
    input  logic [SAMPLE_W-1:0] wav_data,
    output logic                i2s_bclk,
    output logic                i2s_lrck,
    output logic                i2s_dout
);

    localparam int FRAME = frame_bits(SLOT_BITS);
    localparam int BW    = $clog2(FRAME);

    logic                fall_tick;
    logic [BW-1:0]       bit_cnt;
    logic [BW-1:0]       nxt_cnt;
    logic [BW-1:0]       slot_idx;
    logic                frame_start;
    logic                data_bit;
    logic                fetch_hit;
    logic                load_en;
    logic                en_q;
    logic                rden_q;
    logic [SAMPLE_W-1:0] shadow;
    logic [SAMPLE_W-1:0] shift;

    i2s_clk_gen #(
        .BCLK_HALF (BCLK_HALF),
        .SLOT_BITS (SLOT_BITS),
        .BW        (BW)
    ) u_clk_gen (
        .clk_50M   (clk_50M),
        .rst_n     (rst_n),
        .i2s_bclk  (i2s_bclk),
        .i2s_lrck  (i2s_lrck),
        .fall_tick (fall_tick),
        .bit_cnt   (bit_cnt)
    );

    // Data-side decisions are keyed to the bit the current falling
    // edge starts, i.e. the value bit_cnt takes on this tick.
    assign nxt_cnt = (bit_cnt == BW'(FRAME - 1)) ? '0
                                                 : bit_cnt + 1'b1;

    assign slot_idx = (nxt_cnt >= BW'(SLOT_BITS))
                    ? nxt_cnt - BW'(SLOT_BITS)
                    : nxt_cnt;

    assign frame_start = fall_tick & (nxt_cnt == '0);

    assign data_bit = (slot_idx >= BW'(MSB_OFS)) &&
                      (slot_idx <  BW'(MSB_OFS + SAMPLE_W));

`ifdef I2S_WAV_TX_MONO_DUP_EN
    assign fetch_hit = (nxt_cnt == BW'(FRAME - FETCH_LEAD));
`else
    assign fetch_hit = (slot_idx == BW'(SLOT_BITS - FETCH_LEAD));
`endif

    // At frame start the new enable decides the left load, so a
    // frame that begins muted never plays the prefetched sample.
    assign load_en = frame_start ? play_en : en_q;

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            en_q     <= 1'b0;
            wav_rden <= 1'b0;
            rden_q   <= 1'b0;
        end else begin
            if (frame_start)
                en_q <= play_en;
            wav_rden <= fall_tick & fetch_hit & en_q;
            rden_q   <= wav_rden;
        end
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n)
            shadow <= '0;
        else if (!en_q)
            shadow <= '0;
        else if (rden_q)
            shadow <= wav_data;
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            shift    <= '0;
            i2s_dout <= 1'b0;
        end else if (fall_tick) begin
            if (slot_idx == '0) begin
                shift    <= load_en ? shadow : '0;
                i2s_dout <= 1'b0;
            end else if (data_bit) begin
                shift    <= shift << 1;
                i2s_dout <= shift[SAMPLE_W-1];
            end else begin
                i2s_dout <= 1'b0;
            end
        end
    end

endmodule
